sampler: RTL and testbench
==========================

SAMPLER -- requirements
Module: sampler

Interface
Parameters:
REQ-001 WIDTH, default 32, sets the sample width in bits; it SHALL be a multiple of 8.
REQ-002 DIV_W, default 24, sets the width of the divider value in bits.

Ports (name, direction, width, meaning):
REQ-003 clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 rst_i, input, 1, reset; synchronous, active-high.
REQ-005 en_i, input, 1, sampling enable; high while the analyzer is armed or running.
REQ-006 set_div_i, input, 1, one-cycle strobe that loads fdiv_i into the divider register.
REQ-007 fdiv_i, input, DIV_W, divider value; the sample period is fdiv_i+1 clocks.
REQ-008 grp_dis_i, input, WIDTH/8, channel-group disable; bit k zeroes sample byte k.
REQ-009 smpls_i, input, WIDTH, raw asynchronous probe inputs.
REQ-010 stb_o, output, 1, one-cycle sample-valid strobe; feeds stage stb_i.
REQ-011 smpls_o, output, WIDTH, registered sample word; feeds stage smpls_i.

Function
REQ-012 Input synchronizer: sync1 <= smpls_i and sync2 <= sync1 every cycle, independent of en_i.
REQ-013 Divider register div: loads fdiv_i in the cycle set_div_i is high; otherwise holds.
REQ-014 Counter cnt (DIV_W bits) defines tick = en_i && (cnt == div).
REQ-015 cnt update priority, highest first:
- set_div_i high -> cnt <= 0.
- en_i low -> cnt <= 0.
- tick -> cnt <= 0.
- otherwise -> cnt <= cnt+1.
REQ-016 cnt SHALL never exceed div, so it never wraps; div = all-ones gives a period of 2^DIV_W clocks.
REQ-017 On tick, the next cycle has stb_o = 1 and smpls_o = sync2 with byte k forced to 0 wherever grp_dis_i[k] = 1, using grp_dis_i as sampled in the tick cycle.
REQ-018 When not on tick: stb_o <= 0 and smpls_o holds its last value.
REQ-019 Period: with en_i held high and div = D, stb_o pulses exactly once every D+1 clocks; D = 0 gives stb_o high continuously.
REQ-020 First strobe: if en_i rises in cycle t (with cnt = 0), the first tick is in cycle t+D and stb_o is high in cycle t+D+1.
REQ-021 Latency: a value stable on smpls_i from cycle t appears in sync2 in cycle t+2; a tick in cycle t+2 presents it on smpls_o in cycle t+3.
REQ-022 en_i falling: a tick in the same cycle is not generated; stb_o is 0 from the next cycle; smpls_o holds.
REQ-023 set_div_i while en_i is high:
- No tick is generated in that cycle.
- The counter restarts, so the next strobe follows after exactly new_D+1 clocks.
REQ-024 set_div_i and the condition cnt == div in the same cycle: set_div_i wins, so there is no strobe.
REQ-025 grp_dis_i only masks the output word; it SHALL NOT affect strobe timing.

Reset
REQ-026 While rst_i is high, at the next edge these registers SHALL be 0: sync1, sync2, div, cnt, stb_o, smpls_o.
REQ-027 Reset SHALL override set_div_i and en_i.
REQ-028 Reset mid-period SHALL abort the period with no strobe.
REQ-029 After reset is released, div = 0; with en_i high, strobes occur every cycle starting one cycle after the first tick.

Verification
REQ-030 Divider: load fdiv_i=3, en_i=1, smpls_i=32'hA5A5_5A5A constant -> stb_o pulses every 4 clocks, each with smpls_o=32'hA5A5_5A5A; first pulse 4 cycles after en_i rises.
REQ-031 Full rate: div=0, smpls_i incrementing every clock from 0 -> stb_o high continuously; smpls_o equals smpls_i delayed by 3 cycles.
REQ-032 Group mask: div=0, grp_dis_i=4'b0101, smpls_i=32'hFFFF_FFFF -> smpls_o=32'hFF00_FF00.
REQ-033 Re-load mid-period: div=9, load fdiv_i=2 at cnt=5 -> no strobe for the old period; next stb_o exactly 3 clocks after the load cycle's tick-equivalent (tick at load+3, stb_o at load+4).
REQ-034 Enable and reset abort:
- en_i dropped at cnt=div -> no stb_o.
- rst_i asserted mid-period with div=5 -> all outputs 0; div reads back as period 1 (a strobe every cycle) after release with en_i=1.

Source files
------------

// File: rtl/sampler.sv
// rtl/sampler.sv - clock-divided probe sampler with per-byte group masking
module sampler #(
    parameter int WIDTH = 32,
    parameter int DIV_W = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 set_div_i,
    input  logic [DIV_W-1:0]     fdiv_i,
    input  logic [WIDTH/8-1:0]   grp_dis_i,
    input  logic [WIDTH-1:0]     smpls_i,
    output logic                 stb_o,
    output logic [WIDTH-1:0]     smpls_o
);
    localparam int NGRP = WIDTH / 8;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] masked;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic             tick;

    // A divider load restarts the period, so it also suppresses a tick in its own cycle.
    assign tick = en_i && !set_div_i && (cnt == div);

    always_comb begin
        masked = sync2;
        for (int k = 0; k < NGRP; k++) begin
            if (grp_dis_i[k]) begin
                masked[8*k +: 8] = 8'h00;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1   <= '0;
            sync2   <= '0;
            div     <= '0;
            cnt     <= '0;
            stb_o   <= 1'b0;
            smpls_o <= '0;
        end else begin
            sync1 <= smpls_i;
            sync2 <= sync1;
            if (set_div_i) begin
                div <= fdiv_i;
            end
            // cnt clears on every tick, so it never passes div and never wraps.
            if (set_div_i || !en_i || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
            stb_o <= tick;
            if (tick) begin
                smpls_o <= masked;
            end
        end
    end
endmodule

// File: tb/tb_sampler.sv
// tb/tb_sampler.sv - randomized bench for sampler checked against a cycle-history model
module tb_sampler;
    localparam int WIDTH = 32;
    localparam int DIV_W = 24;
    localparam int NGRP  = WIDTH / 8;
    localparam int MAXC  = 8192;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             en_i;
    logic             set_div_i;
    logic [DIV_W-1:0] fdiv_i;
    logic [NGRP-1:0]  grp_dis_i;
    logic [WIDTH-1:0] smpls_i;
    logic             stb_o;
    logic [WIDTH-1:0] smpls_o;

    sampler #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .set_div_i (set_div_i),
        .fdiv_i    (fdiv_i),
        .grp_dis_i (grp_dis_i),
        .smpls_i   (smpls_i),
        .stb_o     (stb_o),
        .smpls_o   (smpls_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: remembers every input cycle; a period runs from run_start and ticks div cycles later.
    logic [WIDTH-1:0] in_h  [MAXC];
    bit               rst_h [MAXC];
    int               cyc = 0;
    longint           run_start = 0;
    logic [DIV_W-1:0] div_m = '0;
    logic             exp_stb = 1'b0;
    logic [WIDTH-1:0] exp_smp = '0;
    bit               model_ok = 1'b0;

    function automatic logic [WIDTH-1:0] apply_mask(input logic [WIDTH-1:0] w, input logic [NGRP-1:0] g);
        logic [WIDTH-1:0] r;
        r = w;
        for (int k = 0; k < NGRP; k++) begin
            if (g[k]) r[8*k +: 8] = 8'h00;
        end
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic [WIDTH-1:0] s2;
        bit               tick;
        in_h[cyc]  = smpls_i;
        rst_h[cyc] = rst_i;
        s2 = '0;
        if (cyc >= 2) begin
            if (!rst_h[cyc-1] && !rst_h[cyc-2]) s2 = in_h[cyc-2];
        end
        if (rst_i) begin
            div_m     = '0;
            run_start = longint'(cyc) + 1;
            exp_stb   = 1'b0;
            exp_smp   = '0;
            model_ok  = 1'b1;
        end else begin
            tick = en_i && !set_div_i && ((longint'(cyc) - run_start) == longint'(div_m));
            if (set_div_i) div_m = fdiv_i;
            if (set_div_i || !en_i || tick) run_start = longint'(cyc) + 1;
            exp_stb = tick;
            if (tick) exp_smp = apply_mask(s2, grp_dis_i);
        end
        if (cyc < MAXC - 1) cyc++;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_stb", {63'd0, stb_o}, {63'd0, exp_stb});
            check("model_smpls", {32'd0, smpls_o}, {32'd0, exp_smp});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b0; set_div_i = 1'b0; fdiv_i = '0;
        grp_dis_i = '0; smpls_i = '0;
        repeat (3) step();
        check("reset_stb", {63'd0, stb_o}, 64'd0);
        check("reset_smpls", {32'd0, smpls_o}, 64'd0);

        // Divide by 4 with a constant pattern
        rst_i = 1'b0; smpls_i = 32'hA5A5_5A5A; set_div_i = 1'b1; fdiv_i = 24'd3;
        step();
        set_div_i = 1'b0;
        repeat (3) step();
        en_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("div3_stb", {63'd0, stb_o}, {63'd0, (i % 4 == 0)});
            if (i % 4 == 0) check("div3_smpls", {32'd0, smpls_o}, 64'hA5A5_5A5A);
        end

        // Group mask at full rate
        set_div_i = 1'b1; fdiv_i = '0; grp_dis_i = 4'b0101; smpls_i = '1;
        step();
        set_div_i = 1'b0;
        repeat (3) step();
        check("mask_stb", {63'd0, stb_o}, 64'd1);
        check("mask_word", {32'd0, smpls_o}, 64'hFF00_FF00);
        check("model_mask_word", {32'd0, exp_smp}, 64'hFF00_FF00);

        // Full rate: output is the input three cycles late
        grp_dis_i = '0;
        for (int j = 0; j < 20; j++) begin
            smpls_i = WIDTH'(j);
            if (j >= 3) begin
                check("rate_stb", {63'd0, stb_o}, 64'd1);
                check("rate_smpls", {32'd0, smpls_o}, 64'(j - 3));
            end
            step();
        end

        // Reload 9 -> 2 at cnt=5
        set_div_i = 1'b1; fdiv_i = 24'd9;
        step();
        set_div_i = 1'b0;
        repeat (5) step();
        set_div_i = 1'b1; fdiv_i = 24'd2;
        step();
        set_div_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("reload_stb", {63'd0, stb_o}, {63'd0, (i == 4)});
            if (i == 4) check("model_reload_stb", {63'd0, exp_stb}, 64'd1);
            if (i < 4) step();
        end

        // Enable dropped in the tick cycle
        en_i = 1'b0; set_div_i = 1'b1; fdiv_i = 24'd3;
        step();
        set_div_i = 1'b0; en_i = 1'b1;
        repeat (3) step();
        en_i = 1'b0;
        step();
        check("en_drop_stb", {63'd0, stb_o}, 64'd0);
        step();
        check("en_drop_stb2", {63'd0, stb_o}, 64'd0);

        // Reset mid-period, then div reads back as 0
        set_div_i = 1'b1; fdiv_i = 24'd5; en_i = 1'b1;
        step();
        set_div_i = 1'b0;
        repeat (3) step();
        rst_i = 1'b1;
        step();
        check("rst_abort_stb", {63'd0, stb_o}, 64'd0);
        check("rst_abort_smpls", {32'd0, smpls_o}, 64'd0);
        rst_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("post_rst_stb", {63'd0, stb_o}, 64'd1);
        end

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 1500; n++) begin
            rst_i     = ($urandom_range(0, 199) == 0);
            en_i      = ($urandom_range(0, 9) != 0);
            set_div_i = ($urandom_range(0, 29) == 0);
            fdiv_i    = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom_range(0, 40))
                                                    : DIV_W'($urandom_range(0, 5));
            grp_dis_i = NGRP'($urandom);
            smpls_i   = $urandom;
            step();
        end
        rst_i = 1'b0; en_i = 1'b0; set_div_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
